sram_burst_master: RTL and testbench

Core-side initiator for the SRAM controller's word interface. Accepts burst commands (base address, length, direction) from the datapath and issues one single-word request at a time to the controller. It streams write data in and read data out, with a small read-return FIFO and an access timeout. It sits between the recognition/feature datapath and the SRAM controller, replacing ad-hoc request logic in client blocks.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/sram_burst_master.sv | 155 +++++++++++++++
 tb/tb_sram_burst_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM word-interface clients: default widths,
// burst-master state encoding and controller timing constants.
package sram_pkg;
  localparam int SRAM_ADDR_W        = 20;
  localparam int SRAM_DATA_W        = 16;
  localparam int SRAM_LEN_W         = 9;
  localparam int LETTER_NUM         = 416;
  localparam int MEM_ACCESS_LATENCY = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head word is always visible on o_rdata.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = i_push && (count_q != CW'(DEPTH));
    pop_ok   = i_pop && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;
endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the SRAM controller word interface: splits a burst command
// into single-word requests, streams write data in and buffers read returns.
module sram_burst_master
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int LEN_W       = SRAM_LEN_W,
  parameter int RFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rdata_valid,
  input  logic              i_rdata_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic              o_err,
  output logic              o_core_mem_request,
  output logic              o_core_mem_wr,
  output logic [ADDR_W-1:0] o_core_mem_addr,
  output logic [DATA_W-1:0] o_core_mem_w_value,
  input  logic [DATA_W-1:0] i_core_mem_r_value,
  input  logic              i_core_wait,
  input  logic              i_mem_valid
);
  localparam int CNT_W = $clog2(RFIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] wval_q, wval_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push, fifo_pop;
  logic              core_wait_unused;

  assign core_wait_unused = i_core_wait;

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    wval_d        = wval_q;
    err_d         = err_q;
    tmo_d         = '0;
    fifo_push     = 1'b0;
    o_wdata_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && rdy_q) begin
          wr_d    = i_cmd_wr;
          addr_d  = i_cmd_addr;
          rem_d   = i_cmd_len;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Zero-length bursts pass through here so o_done lands two cycles after accept.
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (wr_q) begin
          o_wdata_ready = 1'b1;
          if (i_wdata_valid) begin
            wval_d  = i_wdata;
            state_d = S_WAIT;
          end
        end else if (fifo_count < CNT_W'(RFIFO_DEPTH)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (!req_q) begin
          if (i_mem_valid) begin
            fifo_push = !wr_q;
            addr_d    = addr_q + 1'b1;
            rem_d     = rem_q - 1'b1;
            state_d   = (rem_q == LEN_W'(1)) ? S_DONE : S_ISSUE;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_WAIT) && (state_q != S_WAIT);
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      wval_q  <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wval_q  <= wval_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign fifo_pop = o_rdata_valid && i_rdata_ready;

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(RFIFO_DEPTH)
  ) u_rfifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (fifo_push),
    .i_wdata(i_core_mem_r_value),
    .i_pop  (fifo_pop),
    .o_rdata(o_rdata),
    .o_count(fifo_count)
  );

  assign o_rdata_valid      = (fifo_count != '0);
  assign o_cmd_ready        = rdy_q;
  assign o_done             = (state_q == S_DONE);
  assign o_err              = err_q;
  assign o_core_mem_request = req_q;
  assign o_core_mem_wr      = wr_q;
  assign o_core_mem_addr    = addr_q;
  assign o_core_mem_w_value = wval_q;
endmodule

// File: tb/tb_sram_burst_master.sv
// Scoreboard bench for sram_burst_master with a latency-programmable controller model.
module tb_sram_burst_master;
  logic        clk;
  logic        i_rst;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [19:0] i_cmd_addr;
  logic [8:0]  i_cmd_len;
  logic        i_wdata_valid, o_wdata_ready;
  logic [15:0] i_wdata;
  logic        o_rdata_valid, i_rdata_ready;
  logic [15:0] o_rdata;
  logic        o_done, o_err;
  logic        o_core_mem_request, o_core_mem_wr;
  logic [19:0] o_core_mem_addr;
  logic [15:0] o_core_mem_w_value, i_core_mem_r_value;
  logic        i_core_wait, i_mem_valid;

  typedef struct {
    logic [19:0] addr;
    logic        wr;
    logic [15:0] wval;
  } req_t;

  req_t        exp_req_q[$];
  logic [15:0] exp_rd_q[$];
  logic        exp_done_q[$];
  logic [15:0] wq[$];
  int          req_cyc_q[$];
  int          val_cyc_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nreq = 0;
  int ndone = 0;
  int done_cyc = 0;
  int mem_lat = 8;
  bit mem_en = 1'b1;

  sram_burst_master dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_wr          (i_cmd_wr),
    .i_cmd_addr        (i_cmd_addr),
    .i_cmd_len         (i_cmd_len),
    .i_wdata_valid     (i_wdata_valid),
    .o_wdata_ready     (o_wdata_ready),
    .i_wdata           (i_wdata),
    .o_rdata_valid     (o_rdata_valid),
    .i_rdata_ready     (i_rdata_ready),
    .o_rdata           (o_rdata),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_core_mem_request(o_core_mem_request),
    .o_core_mem_wr     (o_core_mem_wr),
    .o_core_mem_addr   (o_core_mem_addr),
    .o_core_mem_w_value(o_core_mem_w_value),
    .i_core_mem_r_value(i_core_mem_r_value),
    .i_core_wait       (i_core_wait),
    .i_mem_valid       (i_mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_req(logic [19:0] a, logic wr, logic [15:0] wv);
    req_t e;
    e.addr = a;
    e.wr   = wr;
    e.wval = wv;
    exp_req_q.push_back(e);
  endtask

  // Request monitor: every pulse must match the next expected request.
  always @(negedge clk) begin : mon_req
    req_t e;
    if (o_core_mem_request === 1'b1) begin
      nreq++;
      req_cyc_q.push_back(cyc);
      if (exp_req_q.size() == 0) begin
        check("unexpected_request", 32'(o_core_mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_req_q.pop_front();
        check("req_addr", 32'(o_core_mem_addr), 32'(e.addr));
        check("req_wr", 32'(o_core_mem_wr), 32'(e.wr));
        if (e.wr) check("req_wval", 32'(o_core_mem_w_value), 32'(e.wval));
      end
    end
  end

  always @(negedge clk) begin : mon_done
    logic e;
    if (o_done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        e = exp_done_q.pop_front();
        check("done_err", 32'(o_err), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_rdata
    logic [15:0] e;
    if (o_rdata_valid === 1'b1 && i_rdata_ready === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        check("unexpected_rdata", 32'(o_rdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_rd_q.pop_front();
        check("rdata", 32'(o_rdata), 32'(e));
      end
    end
  end

  // Controller model: completes each request mem_lat cycles later.
  initial begin : mem_model
    logic [19:0] a;
    i_mem_valid = 1'b0;
    i_core_mem_r_value = '0;
    forever begin
      @(negedge clk);
      i_mem_valid = 1'b0;
      if (o_core_mem_request === 1'b1 && mem_en) begin
        a = o_core_mem_addr;
        repeat (mem_lat) @(negedge clk);
        i_mem_valid = 1'b1;
        i_core_mem_r_value = a[15:0] ^ 16'hC3A5;
        val_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin : wdata_drv
    i_wdata_valid = 1'b0;
    i_wdata = '0;
    forever begin
      @(negedge clk);
      if (i_wdata_valid && o_wdata_ready) begin
        @(posedge clk);
        #1;
        void'(wq.pop_front());
      end
      if (wq.size() > 0) begin
        i_wdata_valid = 1'b1;
        i_wdata = wq[0];
      end else begin
        i_wdata_valid = 1'b0;
      end
    end
  end

  task automatic send_cmd(logic wr, logic [19:0] a, logic [8:0] len, output int acc);
    int k = 0;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_wr = wr;
    i_cmd_addr = a;
    i_cmd_len = len;
    @(negedge clk);
    while (o_cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accepted", 32'(o_cmd_ready), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int target, int budget, string nm);
    int k = 0;
    while (ndone < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(ndone), 32'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, n0, d0, rc, vc, k;
    i_rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_wr = 1'b0;
    i_cmd_addr = '0;
    i_cmd_len = '0;
    i_rdata_ready = 1'b1;
    i_core_wait = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_rdata_valid", 32'(o_rdata_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_request", 32'(o_core_mem_request), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("ready_first_cycle_after_release", 32'(o_cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(o_cmd_ready), 32'd1);

    // Write burst, latency 8
    mem_lat = 8;
    exp_req(20'h00010, 1'b1, 16'hA5A5);
    exp_req(20'h00011, 1'b1, 16'h5A5A);
    exp_req(20'h00012, 1'b1, 16'h0001);
    exp_done_q.push_back(1'b0);
    wq.push_back(16'hA5A5);
    wq.push_back(16'h5A5A);
    wq.push_back(16'h0001);
    n0 = nreq; d0 = ndone; rc = req_cyc_q.size(); vc = val_cyc_q.size();
    send_cmd(1'b1, 20'h00010, 9'd3, acc);
    wait_done(d0 + 1, 300, "wr_done");
    check("wr_req_count", 32'(nreq - n0), 32'd3);
    check("wr_accept_to_req", 32'(req_cyc_q[rc] - acc), 32'd2);
    check("wr_valid_to_next_req", 32'(req_cyc_q[rc+1] - val_cyc_q[vc]), 32'd2);
    check("wr_last_valid_to_done", 32'(done_cyc - val_cyc_q[vc+2]), 32'd1);
    check("wr_err", 32'(o_err), 32'd0);

    // Read burst stalled by a full return FIFO
    repeat (12) @(negedge clk);
    mem_lat = 3;
    i_rdata_ready = 1'b0;
    exp_req(20'h00200, 1'b0, 16'h0); exp_req(20'h00201, 1'b0, 16'h0);
    exp_req(20'h00202, 1'b0, 16'h0); exp_req(20'h00203, 1'b0, 16'h0);
    exp_req(20'h00204, 1'b0, 16'h0); exp_req(20'h00205, 1'b0, 16'h0);
    exp_rd_q.push_back(16'hC1A5); exp_rd_q.push_back(16'hC1A4);
    exp_rd_q.push_back(16'hC1A7); exp_rd_q.push_back(16'hC1A6);
    exp_rd_q.push_back(16'hC1A1); exp_rd_q.push_back(16'hC1A0);
    exp_done_q.push_back(1'b0);
    n0 = nreq; d0 = ndone;
    send_cmd(1'b0, 20'h00200, 9'd6, acc);
    repeat (60) @(negedge clk);
    check("rd_stalled_req_count", 32'(nreq - n0), 32'd4);
    check("rd_stalled_rdata_valid", 32'(o_rdata_valid), 32'd1);
    check("rd_stalled_no_done", 32'(ndone), 32'(d0));
    @(posedge clk);
    #1;
    i_rdata_ready = 1'b1;
    wait_done(d0 + 1, 300, "rd_done");
    check("rd_req_count", 32'(nreq - n0), 32'd6);
    k = 0;
    while (exp_rd_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rd_all_popped", 32'(exp_rd_q.size()), 32'd0);
    @(negedge clk);
    check("rd_fifo_empty", 32'(o_rdata_valid), 32'd0);

    // Timeout: controller never answers
    repeat (12) @(negedge clk);
    mem_en = 1'b0;
    exp_req(20'h00300, 1'b0, 16'h0);
    exp_done_q.push_back(1'b1);
    n0 = nreq; d0 = ndone; rc = req_cyc_q.size();
    send_cmd(1'b0, 20'h00300, 9'd2, acc);
    wait_done(d0 + 1, 200, "to_done");
    check("to_req_count", 32'(nreq - n0), 32'd1);
    check("to_req_to_done", 32'(done_cyc - req_cyc_q[rc]), 32'd32);
    @(negedge clk);
    check("to_err_sticky", 32'(o_err), 32'd1);
    check("to_back_idle", 32'(o_cmd_ready), 32'd1);
    mem_en = 1'b1;

    // Zero-length burst also clears the sticky error
    exp_done_q.push_back(1'b0);
    n0 = nreq; d0 = ndone;
    send_cmd(1'b0, 20'h00123, 9'd0, acc);
    @(negedge clk);
    check("err_cleared_on_accept", 32'(o_err), 32'd0);
    wait_done(d0 + 1, 50, "len0_done");
    check("len0_accept_to_done", 32'(done_cyc - acc), 32'd2);
    check("len0_no_request", 32'(nreq - n0), 32'd0);

    // Address wrap
    repeat (5) @(negedge clk);
    mem_lat = 4;
    exp_req(20'hFFFFF, 1'b0, 16'h0);
    exp_req(20'h00000, 1'b0, 16'h0);
    exp_rd_q.push_back(16'h3C5A);
    exp_rd_q.push_back(16'hC3A5);
    exp_done_q.push_back(1'b0);
    n0 = nreq; d0 = ndone;
    send_cmd(1'b0, 20'hFFFFF, 9'd2, acc);
    wait_done(d0 + 1, 200, "wrap_done");
    check("wrap_req_count", 32'(nreq - n0), 32'd2);

    // Reset during the WAIT of word 2 of 5
    repeat (10) @(negedge clk);
    mem_lat = 8;
    exp_req(20'h00500, 1'b0, 16'h0);
    exp_req(20'h00501, 1'b0, 16'h0);
    exp_rd_q.push_back(16'hC6A5);
    n0 = nreq; d0 = ndone;
    send_cmd(1'b0, 20'h00500, 9'd5, acc);
    k = 0;
    while (nreq - n0 < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_second_request_seen", 32'(nreq - n0), 32'd2);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_request", 32'(o_core_mem_request), 32'd0);
    check("mid_rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("mid_rst_rdata_valid", 32'(o_rdata_valid), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_addr", 32'(o_core_mem_addr), 32'd0);
    @(negedge clk);
    check("mid_rst_ready_after_release", 32'(o_cmd_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", 32'(ndone), 32'(d0));
    check("mid_rst_no_more_requests", 32'(nreq - n0), 32'd2);

    check("left_expected_requests", 32'(exp_req_q.size()), 32'd0);
    check("left_expected_rdata", 32'(exp_rd_q.size()), 32'd0);
    check("left_expected_done", 32'(exp_done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
